// File: rtl/arb_adder2comp_if.sv
// Requester and datapath signal bundle for arb_adder2comp.
// slave = arbiter side, master = requesters plus the external adder datapath.
interface arb_adder2comp_if #(
    parameter int N = 4
);
    logic         req0;
    logic         req1;
    logic [N-1:0] a0;
    logic [N-1:0] b0;
    logic [N-1:0] a1;
    logic [N-1:0] b1;
    logic         gnt0;
    logic         gnt1;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         loadAB;
    logic         loadmagAB;
    logic         comp_mag;
    logic         comp_sinais;
    logic         soma_sub;
    logic         loadRES;
    logic [N:0]   result_in;
    logic [N:0]   res_out;
    logic         done0;
    logic         done1;
    logic         busy;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, result_in,
        output gnt0, gnt1, a, b,
        output loadAB, loadmagAB, comp_mag, comp_sinais, soma_sub, loadRES,
        output res_out, done0, done1, busy
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, result_in,
        input  gnt0, gnt1, a, b,
        input  loadAB, loadmagAB, comp_mag, comp_sinais, soma_sub, loadRES,
        input  res_out, done0, done1, busy
    );
endinterface

// File: rtl/arb_adder2comp.sv
// Two-requester arbiter sequencing a shared two's-complement adder datapath.
// Define ARB_ADDER2COMP_FIXED_PRI_EN for fixed priority (req0 wins); default is round-robin.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and captures operands
// LOAD   | loadAB strobe
// MAG    | loadmagAB strobe
// CMPMAG | comp_mag strobe
// CMPSGN | comp_sinais strobe
// ADDSUB | soma_sub strobe
// LDRES  | loadRES strobe
// CAPT   | result_in captured into res_out; done follows next cycle
module arb_adder2comp #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              RESET,
    arb_adder2comp_if.slave   bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_MAG    = 3'd2;
    localparam logic [2:0] S_CMPMAG = 3'd3;
    localparam logic [2:0] S_CMPSGN = 3'd4;
    localparam logic [2:0] S_ADDSUB = 3'd5;
    localparam logic [2:0] S_LDRES  = 3'd6;
    localparam logic [2:0] S_CAPT   = 3'd7;

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic         owner;
    logic         pick1;
    logic         any_req;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [N:0]   res_q;
    logic         done0_q;
    logic         done1_q;

    assign any_req = bus.req0 | bus.req1;

`ifdef ARB_ADDER2COMP_FIXED_PRI_EN
    always_comb begin
        pick1 = bus.req1 & ~bus.req0;
    end
`else
    // prio1 high means requester 1 wins the next tie (requester 0 was served last)
    logic prio1;

    always_comb begin
        pick1 = 1'b0;
        if (bus.req0 && bus.req1) begin
            pick1 = prio1;
        end else begin
            pick1 = bus.req1;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            prio1 <= 1'b0;
        end else if (state == S_IDLE && any_req) begin
            prio1 <= ~pick1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (any_req) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_MAG;
            S_MAG:    state_nxt = S_CMPMAG;
            S_CMPMAG: state_nxt = S_CMPSGN;
            S_CMPSGN: state_nxt = S_ADDSUB;
            S_ADDSUB: state_nxt = S_LDRES;
            S_LDRES:  state_nxt = S_CAPT;
            S_CAPT:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state   <= S_IDLE;
            owner   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            done0_q <= (state == S_CAPT) && !owner;
            done1_q <= (state == S_CAPT) && owner;
            // operands are frozen at the grant edge; later input changes are ignored
            if (state == S_IDLE && any_req) begin
                owner <= pick1;
                a_q   <= pick1 ? bus.a1 : bus.a0;
                b_q   <= pick1 ? bus.b1 : bus.b0;
            end
            if (state == S_CAPT) begin
                res_q <= bus.result_in;
            end
        end
    end

    assign bus.busy        = (state != S_IDLE);
    assign bus.gnt0        = (state != S_IDLE) && !owner;
    assign bus.gnt1        = (state != S_IDLE) && owner;
    assign bus.a           = a_q;
    assign bus.b           = b_q;
    assign bus.res_out     = res_q;
    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.loadAB      = (state == S_LOAD);
    assign bus.loadmagAB   = (state == S_MAG);
    assign bus.comp_mag    = (state == S_CMPMAG);
    assign bus.comp_sinais = (state == S_CMPSGN);
    assign bus.soma_sub    = (state == S_ADDSUB);
    assign bus.loadRES     = (state == S_LDRES);
endmodule

// File: tb/tb_arb_adder2comp.sv
// Self-checking bench for arb_adder2comp: an external adder model feeds result_in,
// a negedge monitor logs transactions, and scenario tasks compare against a reference model.
`timescale 1ns/1ps
module tb_arb_adder2comp;
    localparam int N = 4;
    localparam int W = N + 1;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    arb_adder2comp_if #(.N(N)) bus();
    arb_adder2comp #(.N(N)) dut (.clk(clk), .RESET(RESET), .bus(bus));

    // the shared datapath: a plain signed sum of the operands the arbiter presents
    assign bus.result_in = {bus.a[N-1], bus.a} + {bus.b[N-1], bus.b};

    int vectors = 0;
    int miscompares = 0;
    int model_last = 1;

    // transaction monitor
    int         cyc = 0;
    int         overlaps = 0;
    int         strays = 0;
    int         busy_bad = 0;
    int         gnt_q[$];
    int         done_q[$];
    int         lat_q[$];
    int         len_q[$];
    logic [N:0] res_q[$];
    logic [41:0] trace_q[$];
    logic       g_prev = 1'b0;
    int         g_cyc = 0;
    int         g_len = 0;
    logic [41:0] trace = '0;
    logic [5:0] strobes;

    assign strobes = {bus.loadAB, bus.loadmagAB, bus.comp_mag,
                      bus.comp_sinais, bus.soma_sub, bus.loadRES};

    always @(negedge clk) begin
        cyc++;
        if (bus.gnt0 && bus.gnt1) overlaps++;
        if (bus.busy !== (bus.gnt0 | bus.gnt1)) busy_bad++;
        if (!(bus.gnt0 | bus.gnt1) && (strobes != 6'b0)) strays++;
        if ((bus.gnt0 | bus.gnt1) && !g_prev) begin
            gnt_q.push_back(bus.gnt1 ? 1 : 0);
            g_cyc = cyc;
            g_len = 0;
            trace = '0;
        end
        if (bus.gnt0 | bus.gnt1) begin
            g_len++;
            trace = {trace[35:0], strobes};
        end
        if (bus.done0 | bus.done1) begin
            done_q.push_back((bus.done0 && bus.done1) ? 2 : (bus.done1 ? 1 : 0));
            res_q.push_back(bus.res_out);
            lat_q.push_back(cyc - g_cyc);
            len_q.push_back(g_len);
            trace_q.push_back(trace);
        end
        g_prev = bus.gnt0 | bus.gnt1;
    end

    // reference model
    function automatic int model_pick(bit r0, bit r1);
`ifdef ARB_ADDER2COMP_FIXED_PRI_EN
        return r0 ? 0 : 1;
`else
        if (r0 && r1) return (model_last == 0) ? 1 : 0;
        return r1 ? 1 : 0;
`endif
    endfunction

    function automatic logic [N:0] model_sum(logic [N-1:0] x, logic [N-1:0] y);
        int sx;
        int sy;
        sx = (x >= (1 << (N - 1))) ? int'(x) - (1 << N) : int'(x);
        sy = (y >= (1 << (N - 1))) ? int'(y) - (1 << N) : int'(y);
        return W'(sx + sy);
    endfunction

    function automatic logic [41:0] exp_trace();
        logic [41:0] t;
        t = '0;
        for (int k = 0; k < 7; k++) begin
            t = t << 6;
            if (k < 6) t[5 - k] = 1'b1;
        end
        return t;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        gnt_q.delete();
        done_q.delete();
        lat_q.delete();
        len_q.delete();
        res_q.delete();
        trace_q.delete();
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        model_last = 1;
        clear_log();
    endtask

    task automatic wait_dones(int n, int budget, string name);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (done_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: dones seen %0d, required %0d", name, done_q.size(), n);
        end
    endtask

    task automatic test_reset();
        bus.req0 = 1'b1;
        bus.a0 = 4'b0110;
        bus.b0 = 4'b0001;
        RESET = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.gnt0, bus.gnt1, bus.busy, bus.done0, bus.done1} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {bus.gnt0, bus.gnt1, bus.busy, bus.done0, bus.done1});
        end
        vectors++;
        if (strobes !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b required 000000", strobes);
        end
        vectors++;
        if ({bus.a, bus.b, bus.res_out} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: a=%b b=%b res_out=%b required all zero",
                     bus.a, bus.b, bus.res_out);
        end
        bus.req0 = 1'b0;
        tick();
        RESET = 1'b0;
        model_last = 1;
        clear_log();
    endtask

    task automatic test_single();
        logic [N:0] keep;
        apply_reset();
        bus.a0 = 4'b1101;
        bus.b0 = 4'b0101;
        bus.req0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        wait_dones(1, 20, "single");
        vectors++;
        if (gnt_q[0] !== 0 || done_q[0] !== 0) begin
            miscompares++;
            $display("FAIL single_owner: gnt %0d done %0d required 0/0", gnt_q[0], done_q[0]);
        end
        vectors++;
        if (res_q[0] !== 5'b00010) begin
            miscompares++;
            $display("FAIL single_res: got %b required 00010", res_q[0]);
        end
        vectors++;
        if (lat_q[0] !== 7 || len_q[0] !== 7) begin
            miscompares++;
            $display("FAIL single_timing: latency %0d gnt cycles %0d required 7/7", lat_q[0], len_q[0]);
        end
        vectors++;
        if (trace_q[0] !== exp_trace()) begin
            miscompares++;
            $display("FAIL single_strobes: got %h required %h", trace_q[0], exp_trace());
        end
        keep = bus.res_out;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (bus.res_out !== 5'b00010 || keep !== 5'b00010) begin
            miscompares++;
            $display("FAIL single_hold: got %b required 00010", bus.res_out);
        end
    endtask

    task automatic test_simultaneous();
        int k;
        apply_reset();
        bus.a0 = 4'd2;
        bus.b0 = 4'd3;
        bus.a1 = 4'b1000;
        bus.b1 = 4'b1000;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        k = 0;
        while (!bus.gnt1 && k < 20) begin
            tick();
            k++;
        end
        bus.req1 = 1'b0;
        wait_dones(2, 30, "simultaneous");
        vectors++;
        if (gnt_q.size() !== 2 || gnt_q[0] !== 0 || gnt_q[1] !== 1) begin
            miscompares++;
            $display("FAIL simul_order: got %0d grants first %0d second %0d required 2 grants 0 then 1",
                     gnt_q.size(), gnt_q[0], gnt_q[1]);
        end
        vectors++;
        if (done_q[0] !== 0 || done_q[1] !== 1) begin
            miscompares++;
            $display("FAIL simul_done: got %0d,%0d required 0,1", done_q[0], done_q[1]);
        end
        vectors++;
        if (res_q[0] !== 5'b00101 || res_q[1] !== 5'b10000) begin
            miscompares++;
            $display("FAIL simul_res: got %b,%b required 00101,10000", res_q[0], res_q[1]);
        end
        vectors++;
        if (lat_q[1] !== 7 || trace_q[1] !== exp_trace()) begin
            miscompares++;
            $display("FAIL simul_second_timing: latency %0d required 7", lat_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        apply_reset();
        bus.a0 = 4'($urandom_range(0, 15));
        bus.b0 = 4'($urandom_range(0, 15));
        bus.a1 = 4'($urandom_range(0, 15));
        bus.b1 = 4'($urandom_range(0, 15));
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        wait_dones(4, 60, "back_to_back");
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (gnt_q.size() !== 4) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d grants required 4", gnt_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            w = model_pick(1'b1, 1'b1);
            model_last = w;
            vectors++;
            if (gnt_q[i] !== w || done_q[i] !== w) begin
                miscompares++;
                $display("FAIL b2b_order[%0d]: gnt %0d done %0d required %0d", i, gnt_q[i], done_q[i], w);
            end
            vectors++;
            if (res_q[i] !== (w == 1 ? model_sum(bus.a1, bus.b1) : model_sum(bus.a0, bus.b0))) begin
                miscompares++;
                $display("FAIL b2b_res[%0d]: got %b", i, res_q[i]);
            end
        end
`ifdef ARB_ADDER2COMP_FIXED_PRI_EN
        vectors++;
        if (gnt_q.sum() !== 0) begin
            miscompares++;
            $display("FAIL fixed_pri_gnt1: gnt1 grants %0d required 0", gnt_q.sum());
        end
`endif
        vectors++;
        if (overlaps !== 0) begin
            miscompares++;
            $display("FAIL b2b_overlap: got %0d overlapping cycles required 0", overlaps);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.a0 = 4'd3;
        bus.b0 = 4'd2;
        bus.req0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        wait_dones(1, 20, "reset_mid_pre");
        tick();
        bus.a0 = 4'd1;
        bus.req0 = 1'b1;
        tick();
        bus.req0 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        vectors++;
        if (bus.soma_sub !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_phase: soma_sub %b required 1", bus.soma_sub);
        end
        RESET = 1'b1;
        tick();
        vectors++;
        if ({bus.gnt0, bus.gnt1, bus.busy, bus.done0, bus.done1, strobes} !== '0 ||
            {bus.a, bus.b, bus.res_out} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: ctrl %b a=%b b=%b res_out=%b required all zero",
                     {bus.gnt0, bus.gnt1, bus.busy, bus.done0, bus.done1, strobes},
                     bus.a, bus.b, bus.res_out);
        end
        RESET = 1'b0;
        model_last = 1;
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (done_q.size() !== 1) begin
            miscompares++;
            $display("FAIL reset_mid_nodone: got %0d dones required 1", done_q.size());
        end
        bus.a1 = 4'b1111;
        bus.b1 = 4'b0100;
        bus.req1 = 1'b1;
        tick();
        bus.req1 = 1'b0;
        vectors++;
        if (bus.loadAB !== 1'b1 || bus.gnt1 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_restart: loadAB %b gnt1 %b required 1/1", bus.loadAB, bus.gnt1);
        end
        wait_dones(2, 20, "reset_mid_post");
        vectors++;
        if (res_q[1] !== 5'b00011 || lat_q[1] !== 7 || trace_q[1] !== exp_trace()) begin
            miscompares++;
            $display("FAIL reset_mid_post: res %b latency %0d required 00011/7", res_q[1], lat_q[1]);
        end
    endtask

    task automatic test_operand_change();
        apply_reset();
        bus.a0 = 4'b1101;
        bus.b0 = 4'b0101;
        bus.req0 = 1'b1;
        tick();
        tick();
        bus.a0 = 4'b0111;
        bus.req0 = 1'b0;
        wait_dones(1, 20, "operand_change");
        vectors++;
        if (res_q[0] !== 5'b00010 || bus.a !== 4'b1101) begin
            miscompares++;
            $display("FAIL operand_change: res %b a %b required 00010/1101", res_q[0], bus.a);
        end
    endtask

    task automatic test_random();
        bit r0;
        bit r1;
        int w;
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N:0] e;
        apply_reset();
        for (int i = 0; i < 25; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            bus.a0 = 4'($urandom_range(0, 15));
            bus.b0 = 4'($urandom_range(0, 15));
            bus.a1 = 4'($urandom_range(0, 15));
            bus.b1 = 4'($urandom_range(0, 15));
            w = model_pick(r0, r1);
            model_last = w;
            x = (w == 1) ? bus.a1 : bus.a0;
            y = (w == 1) ? bus.b1 : bus.b0;
            e = model_sum(x, y);
            bus.req0 = r0;
            bus.req1 = r1;
            tick();
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            bus.a0 = 4'($urandom_range(0, 15));
            bus.a1 = 4'($urandom_range(0, 15));
            vectors++;
            if ({bus.gnt1, bus.gnt0} !== ((w == 1) ? 2'b10 : 2'b01)) begin
                miscompares++;
                $display("FAIL rand_gnt[%0d]: got %b winner required %0d", i, {bus.gnt1, bus.gnt0}, w);
            end
            wait_dones(i + 1, 20, "random");
            vectors++;
            if (done_q[i] !== w || res_q[i] !== e || lat_q[i] !== 7) begin
                miscompares++;
                $display("FAIL rand_txn[%0d]: done %0d res %b lat %0d required %0d %b 7",
                         i, done_q[i], res_q[i], lat_q[i], w, e);
            end
        end
        vectors++;
        if (overlaps !== 0 || strays !== 0 || busy_bad !== 0) begin
            miscompares++;
            $display("FAIL global: overlaps %0d stray strobes %0d busy errors %0d required 0",
                     overlaps, strays, busy_bad);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0 = '0;
        bus.b0 = '0;
        bus.a1 = '0;
        bus.b1 = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_operand_change();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/arb_adder2comp.md
ARB_ADDER2COMP -- requirements
Module: arb_adder2comp

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width of the shared two's-complement adder datapath.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 req0 / req1  in  1 each  operation request from requester 0 / 1.
REQ-005 a0, b0 / a1, b1  in  N each  signed two's-complement operands of requester 0 / 1.
REQ-006 gnt0 / gnt1  out  1 each  high while requester 0 / 1 owns the datapath.
REQ-007 a / b  out  N each  captured operands driven to the datapath.
REQ-008 loadAB, loadmagAB, comp_mag, comp_sinais, soma_sub, loadRES  out  1 each  datapath step strobes.
REQ-009 result_in  in  N+1  datapath result.
REQ-010 res_out  out  N+1  registered result of the last completed operation.
REQ-011 done0 / done1  out  1 each  one-cycle completion pulse for requester 0 / 1.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, MAG, CMPMAG, CMPSGN, ADDSUB, LDRES and CAPT; each non-IDLE state SHALL last exactly one cycle and advance in that order, and CAPT SHALL return to IDLE.
REQ-014 In IDLE, if req0 or req1 is sampled high, the FSM SHALL select one winner per REQ-015, capture that requester's operands into the a/b registers and go to LOAD; with no request it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; with one request high, that requester wins.
REQ-016 gnt of the winner SHALL be high from LOAD through CAPT inclusive; at most one gnt SHALL be high at any time.
REQ-017 The strobes loadAB, loadmagAB, comp_mag, comp_sinais, soma_sub and loadRES SHALL each be high in LOAD, MAG, CMPMAG, CMPSGN, ADDSUB and LDRES respectively; exactly one strobe is high in those states, and none in IDLE or CAPT.
REQ-018 In CAPT, res_out SHALL load result_in, and the winner's done SHALL be registered high for the following cycle only.
REQ-019 Latency: done is high in the 8th cycle after the IDLE cycle that sampled the request, i.e. 7 clock edges after the grant edge.
REQ-020 Operand changes and request deassertion after the grant edge SHALL NOT affect the running operation.
REQ-021 A request that is still high in the cycle carrying its own done SHALL be treated as a new request and subject to arbitration.
REQ-022 res_out SHALL hold its value until the next CAPT.

Reset
REQ-023 While RESET is high at a clock edge, the FSM SHALL enter IDLE, all strobes, gnt0, gnt1, done0, done1 and busy SHALL be 0, a, b and res_out SHALL be 0, and the round-robin pointer SHALL favour requester 0.
REQ-024 RESET SHALL take priority over every other event; if asserted mid-operation, the operation SHALL be abandoned with no done pulse.

Configuration
REQ-025 With macro ARB_ADDER2COMP_FIXED_PRI_EN defined, arbitration SHALL be fixed priority with req0 always winning over req1, and the pointer SHALL be removed; without the macro, arbitration SHALL be round-robin per REQ-015.

Verification
REQ-026 After reset, req0=1 with a0=-3 (1101) and b0=5 (0101) -> gnt0 is high for 7 cycles, each strobe pulses once in order, done0 pulses 7 edges after the grant, and res_out=00010.
REQ-027 After reset, req0 and req1 are raised in the same cycle with a0=2, b0=3, a1=-8, b1=-8 -> requester 0 is served first with res_out=00101 and done0; requester 1 follows with res_out=10000 and done1.
REQ-028 req0 and req1 are held high continuously -> the grant order is 0,1,0,1, and no gnt overlaps another.
REQ-029 RESET is pulsed during ADDSUB -> on the next cycle all outputs are 0, there is no done pulse, and the next request restarts from LOAD.
REQ-030 a0 is changed from 1101 to 0111 one cycle after the grant -> the result still reflects a0=-3.
REQ-031 With ARB_ADDER2COMP_FIXED_PRI_EN defined and both requests held high -> requester 0 is served on every transaction and gnt1 never asserts.
